// File: rtl/generic_fifo_pkg.sv
// Shared helpers for the generic multi-channel FIFO envelope: width math and RAM addressing.
package generic_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

  // Counts run 0..NUM_OF_ENTRIES inclusive, so one bit wider than a pointer.
  function automatic int unsigned cnt_width(input int unsigned ptr_width);
    return ptr_width + 1;
  endfunction

  function automatic int unsigned ram_addr(input int unsigned ch, input int unsigned ptr,
                                           input int unsigned ptr_width);
    return (ch << ptr_width) | ptr;
  endfunction

endpackage

// File: rtl/generic_1clk_ram_1r1w_mask.sv
// Single-clock 1r1w RAM with bit-masked write and synchronous read; no reset on contents.
module generic_1clk_ram_1r1w_mask #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DAT_W  = 40,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DAT_W-1:0]  wdata,
  input  logic [DAT_W-1:0]  wmask,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DAT_W-1:0]  rdata
);

  logic [DAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/generic_mc_fifo_env_ram.sv
// Multi-channel FIFO envelope: NUM_CH independent FIFOs sharing one masked 1r1w RAM,
// with per-channel count/flags, sticky errors and registered read data.
module generic_mc_fifo_env_ram
  import generic_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CH_W           = 2,
  parameter int unsigned PTR_WIDTH      = 10,
  parameter int unsigned NUM_OF_ENTRIES = 600,
  parameter int unsigned DAT_WIDTH      = 40
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_op,
  input  logic [CH_W-1:0]                  wr_ch,
  input  logic [DAT_WIDTH-1:0]             wr_data,
  input  logic [DAT_WIDTH-1:0]             wr_mask,
  input  logic                             rd_op,
  input  logic [CH_W-1:0]                  rd_ch,
  output logic [DAT_WIDTH-1:0]             rd_data,
  output logic                             rd_valid,
  input  logic [PTR_WIDTH:0]               afull_thr,
  output logic [NUM_CH-1:0]                full,
  output logic [NUM_CH-1:0]                empty,
  output logic [NUM_CH-1:0]                afull,
  output logic [NUM_CH*(PTR_WIDTH+1)-1:0]  entry_used,
  input  logic                             err_clr,
  output logic [NUM_CH-1:0]                wr_full_err,
  output logic [NUM_CH-1:0]                rd_empty_err
);

  localparam int unsigned CNT_W  = cnt_width(PTR_WIDTH);
  localparam int unsigned ADDR_W = CH_W + PTR_WIDTH;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(NUM_OF_ENTRIES);

  if (64'(NUM_OF_ENTRIES) > (64'd1 << PTR_WIDTH)) begin : g_bad_depth
    $error("NUM_OF_ENTRIES does not fit in PTR_WIDTH");
  end
  if (64'(NUM_CH) > (64'd1 << CH_W)) begin : g_bad_ch
    $error("NUM_CH does not fit in CH_W");
  end

  logic [NUM_CH-1:0]           wr_sel, rd_sel, wr_acc, rd_acc;
  logic [NUM_CH*PTR_WIDTH-1:0] wr_ptr_all, rd_ptr_all;
  logic [PTR_WIDTH-1:0]        wr_ptr_sel, rd_ptr_sel;
  logic [ADDR_W-1:0]           wr_addr, rd_addr;
  logic [DAT_WIDTH-1:0]        ram_rdata, hold_q;
  logic                        rd_valid_q;
  logic [NUM_CH-1:0]           wr_err_q, rd_err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;

    assign wr_sel[c] = wr_op && (wr_ch == CH_W'(c));
    assign rd_sel[c] = rd_op && (rd_ch == CH_W'(c));
    // Gating on registered flags keeps a read off the row being written this cycle.
    assign wr_acc[c] = wr_sel[c] & ~full[c];
    assign rd_acc[c] = rd_sel[c] & ~empty[c];

    assign full[c]  = (cnt_q == FULL_CNT);
    assign empty[c] = (cnt_q == '0);
    assign afull[c] = (cnt_q >= afull_thr);
    assign entry_used[c*CNT_W +: CNT_W]     = cnt_q;
    assign wr_ptr_all[c*PTR_WIDTH +: PTR_WIDTH] = wr_ptr_q;
    assign rd_ptr_all[c*PTR_WIDTH +: PTR_WIDTH] = rd_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (wr_acc[c]) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc[c]) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (wr_acc[c] && !rd_acc[c]) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (!wr_acc[c] && rd_acc[c]) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_sel = '0;
    rd_ptr_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_sel[c]) wr_ptr_sel = wr_ptr_all[c*PTR_WIDTH +: PTR_WIDTH];
      if (rd_sel[c]) rd_ptr_sel = rd_ptr_all[c*PTR_WIDTH +: PTR_WIDTH];
    end
  end

  assign wr_addr = ADDR_W'(ram_addr(32'(wr_ch), 32'(wr_ptr_sel), PTR_WIDTH));
  assign rd_addr = ADDR_W'(ram_addr(32'(rd_ch), 32'(rd_ptr_sel), PTR_WIDTH));

  generic_1clk_ram_1r1w_mask #(
    .ADDR_W (ADDR_W),
    .DAT_W  (DAT_WIDTH),
    .DEPTH  (NUM_CH << PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (|wr_acc),
    .waddr (wr_addr),
    .wdata (wr_data),
    .wmask (wr_mask),
    .re    (|rd_acc),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
      wr_err_q   <= '0;
      rd_err_q   <= '0;
    end else begin
      rd_valid_q <= |rd_acc;
      if (rd_valid_q) hold_q <= ram_rdata;
      // A new error in the clearing cycle survives the clear.
      wr_err_q <= (err_clr ? '0 : wr_err_q) | (wr_sel & full);
      rd_err_q <= (err_clr ? '0 : rd_err_q) | (rd_sel & empty);
    end
  end

  // RAM output is only fresh for one cycle; hold_q keeps it stable until the next read.
  assign rd_data      = rd_valid_q ? ram_rdata : hold_q;
  assign rd_valid     = rd_valid_q;
  assign wr_full_err  = wr_err_q;
  assign rd_empty_err = rd_err_q;

endmodule
